// File: rtl/ir_pkg.sv
// Shared types, NEC frame field offsets and a saturating-add helper for the
// IR command controller.
package ir_pkg;

  typedef enum logic [1:0] {
    EVT_NONE    = 2'd0,
    EVT_PRESS   = 2'd1,
    EVT_REPEAT  = 2'd2,
    EVT_RELEASE = 2'd3
  } evt_type_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    HELD  = 2'd2
  } ctrl_state_t;

  localparam int unsigned NEC_ADDR_LSB   = 24;
  localparam int unsigned NEC_ADDR_N_LSB = 16;
  localparam int unsigned NEC_CMD_LSB    = 8;
  localparam int unsigned NEC_CMD_N_LSB  = 0;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, v} + {7'b0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/ir_hold_timer.sv
// Loadable down-counter for key-hold tracking; expired_out pulses on the
// cycle the count steps from 1 to 0 while enabled.
module ir_hold_timer #(
  parameter int unsigned HOLD_CYCLES = 12_000_000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic load_in,
  input  logic en_in,
  output logic expired_out
);

  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_in) begin
      cnt_d = LOAD_VAL;
    end else if (en_in && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_out = en_in && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/ir_command_ctrl.sv
// Validates decoded NEC frames, tracks key hold/release and issues
// PRESS/REPEAT/RELEASE events over a 1-deep valid/ready output register.
module ir_command_ctrl
  import ir_pkg::*;
#(
  parameter logic [7:0]  DEV_ADDR    = 8'h00,
  parameter bit          ADDR_FILTER = 1'b1,
  parameter int unsigned HOLD_CYCLES = 12_000_000,
  parameter int unsigned REPEAT_DIV  = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] code_in,
  input  logic        new_code_in,
  input  logic [2:0]  error_in,
  output logic        evt_valid_out,
  input  logic        evt_ready_in,
  output logic [1:0]  evt_type_out,
  output logic [7:0]  evt_cmd_out,
  output logic        held_out,
  output logic [7:0]  err_cnt_out,
  output logic [7:0]  rej_cnt_out,
  output logic [7:0]  drop_cnt_out
);

  localparam int unsigned DIV_W = $clog2(REPEAT_DIV + 1);

  ctrl_state_t state_q, state_d;
  logic             prev_held_q, prev_held_d;
  logic             held_q, held_d;
  logic [7:0]       cur_cmd_q, cur_cmd_d;
  logic [DIV_W-1:0] div_q, div_d, div_inc;
  logic [31:0]      cap_code_q, cap_code_d;
  logic             pend_vld_q, pend_vld_d;
  logic [7:0]       pend_cmd_q, pend_cmd_d;
  logic             evt_vld_q, evt_vld_d;
  evt_type_t        evt_type_q, evt_type_d;
  logic [7:0]       evt_cmd_q, evt_cmd_d;
  logic [7:0]       err_cnt_q, rej_cnt_q, drop_cnt_q;

  logic       accept_code, timer_load, timer_exp, pend_set, drop;
  logic       gen_vld, frame_ok;
  evt_type_t  gen_type;
  logic [7:0] gen_cmd;
  logic [1:0] rej_inc;
  logic [7:0] f_addr, f_addr_n, f_cmd, f_cmd_n;

  ir_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .load_in    (timer_load),
    .en_in      (held_q),
    .expired_out(timer_exp)
  );

  assign f_addr   = cap_code_q[NEC_ADDR_LSB   +: 8];
  assign f_addr_n = cap_code_q[NEC_ADDR_N_LSB +: 8];
  assign f_cmd    = cap_code_q[NEC_CMD_LSB    +: 8];
  assign f_cmd_n  = cap_code_q[NEC_CMD_N_LSB  +: 8];
  assign frame_ok = (f_addr == ~f_addr_n) && (f_cmd == ~f_cmd_n) &&
                    (!ADDR_FILTER || (f_addr == DEV_ADDR));
  assign div_inc  = div_q + DIV_W'(1);
  assign cap_code_d = accept_code ? code_in : cap_code_q;

  always_comb begin
    state_d     = state_q;
    prev_held_d = prev_held_q;
    held_d      = held_q;
    cur_cmd_d   = cur_cmd_q;
    div_d       = div_q;
    accept_code = 1'b0;
    timer_load  = 1'b0;
    pend_set    = 1'b0;
    gen_vld     = 1'b0;
    gen_type    = EVT_NONE;
    gen_cmd     = cur_cmd_q;
    rej_inc     = 2'd0;
    unique case (state_q)
      IDLE: begin
        if (new_code_in) begin
          if (pend_vld_q) begin
            rej_inc = 2'd1;
          end else begin
            accept_code = 1'b1;
            prev_held_d = 1'b0;
            state_d     = CHECK;
          end
        end
      end
      HELD: begin
        if (timer_exp) begin
          gen_vld  = 1'b1;
          gen_type = EVT_RELEASE;
          held_d   = 1'b0;
          state_d  = IDLE;
        end
        if (new_code_in) begin
          if (pend_vld_q) begin
            rej_inc = 2'd1;
          end else begin
            accept_code = 1'b1;
            prev_held_d = !timer_exp;
            state_d     = CHECK;
          end
        end
      end
      CHECK: begin
        // The checked frame is in cap_code_q; anything arriving now is dropped.
        if (new_code_in) rej_inc = 2'd1;
        state_d = prev_held_q ? HELD : IDLE;
        if (!frame_ok) begin
          rej_inc = rej_inc + 2'd1;
          if (prev_held_q && timer_exp) begin
            gen_vld  = 1'b1;
            gen_type = EVT_RELEASE;
            held_d   = 1'b0;
            state_d  = IDLE;
          end
        end else if (!prev_held_q) begin
          gen_vld    = 1'b1;
          gen_type   = EVT_PRESS;
          gen_cmd    = f_cmd;
          held_d     = 1'b1;
          cur_cmd_d  = f_cmd;
          div_d      = '0;
          timer_load = 1'b1;
          state_d    = HELD;
        end else if (f_cmd == cur_cmd_q) begin
          timer_load = 1'b1;
          state_d    = HELD;
          if (div_inc == DIV_W'(REPEAT_DIV)) begin
            gen_vld  = 1'b1;
            gen_type = EVT_REPEAT;
            div_d    = '0;
          end else begin
            div_d = div_inc;
          end
        end else begin
          // Key change: release the old key now, park the new PRESS.
          gen_vld    = 1'b1;
          gen_type   = EVT_RELEASE;
          pend_set   = 1'b1;
          cur_cmd_d  = f_cmd;
          div_d      = '0;
          timer_load = 1'b1;
          state_d    = HELD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    evt_vld_d  = evt_vld_q;
    evt_type_d = evt_type_q;
    evt_cmd_d  = evt_cmd_q;
    pend_vld_d = pend_vld_q;
    pend_cmd_d = pend_cmd_q;
    drop       = 1'b0;
    if (pend_set) begin
      pend_vld_d = 1'b1;
      pend_cmd_d = f_cmd;
    end
    if (!evt_vld_q || evt_ready_in) begin
      if (pend_vld_q) begin
        evt_vld_d  = 1'b1;
        evt_type_d = EVT_PRESS;
        evt_cmd_d  = pend_cmd_q;
        pend_vld_d = 1'b0;
        drop       = gen_vld;
      end else if (gen_vld) begin
        evt_vld_d  = 1'b1;
        evt_type_d = gen_type;
        evt_cmd_d  = gen_cmd;
      end else begin
        evt_vld_d = 1'b0;
      end
    end else begin
      drop = gen_vld;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      prev_held_q <= 1'b0;
      held_q      <= 1'b0;
      cur_cmd_q   <= 8'h00;
      div_q       <= '0;
      cap_code_q  <= 32'h0;
      pend_vld_q  <= 1'b0;
      pend_cmd_q  <= 8'h00;
      evt_vld_q   <= 1'b0;
      evt_type_q  <= EVT_NONE;
      evt_cmd_q   <= 8'h00;
      err_cnt_q   <= 8'h00;
      rej_cnt_q   <= 8'h00;
      drop_cnt_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      prev_held_q <= prev_held_d;
      held_q      <= held_d;
      cur_cmd_q   <= cur_cmd_d;
      div_q       <= div_d;
      cap_code_q  <= cap_code_d;
      pend_vld_q  <= pend_vld_d;
      pend_cmd_q  <= pend_cmd_d;
      evt_vld_q   <= evt_vld_d;
      evt_type_q  <= evt_type_d;
      evt_cmd_q   <= evt_cmd_d;
      err_cnt_q   <= sat_inc(err_cnt_q, {1'b0, (error_in != 3'b000)});
      rej_cnt_q   <= sat_inc(rej_cnt_q, rej_inc);
      drop_cnt_q  <= sat_inc(drop_cnt_q, {1'b0, drop});
    end
  end

  assign evt_valid_out = evt_vld_q;
  assign evt_type_out  = evt_type_q;
  assign evt_cmd_out   = evt_cmd_q;
  assign held_out      = held_q;
  assign err_cnt_out   = err_cnt_q;
  assign rej_cnt_out   = rej_cnt_q;
  assign drop_cnt_out  = drop_cnt_q;

endmodule

// File: tb/tb_ir_command_ctrl.sv
// Directed bench for ir_command_ctrl with a short hold time and REPEAT_DIV=3.
module tb_ir_command_ctrl;

  localparam int unsigned H = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] code = 32'h0;
  logic        new_code = 1'b0;
  logic [2:0]  err = 3'b000;
  logic        ready = 1'b1;
  logic        evt_valid, held;
  logic [1:0]  evt_type;
  logic [7:0]  evt_cmd, err_cnt, rej_cnt, drop_cnt;

  int vectors = 0;
  int miscompares = 0;

  ir_command_ctrl #(
    .DEV_ADDR   (8'h00),
    .ADDR_FILTER(1'b1),
    .HOLD_CYCLES(H),
    .REPEAT_DIV (3)
  ) dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .code_in      (code),
    .new_code_in  (new_code),
    .error_in     (err),
    .evt_valid_out(evt_valid),
    .evt_ready_in (ready),
    .evt_type_out (evt_type),
    .evt_cmd_out  (evt_cmd),
    .held_out     (held),
    .err_cnt_out  (err_cnt),
    .rej_cnt_out  (rej_cnt),
    .drop_cnt_out (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_evt(input string tag, input logic v, input logic [1:0] t, input logic [7:0] c);
    chk({tag, ".vld"}, 32'(evt_valid), 32'(v));
    if (v) begin
      chk({tag, ".type"}, 32'(evt_type), 32'(t));
      chk({tag, ".cmd"}, 32'(evt_cmd), 32'(c));
    end
  endtask

  task automatic send(input logic [31:0] c);
    code = c;
    new_code = 1'b1;
    tick(1);
    new_code = 1'b0;
  endtask

  initial begin
    int n;
    // Reset state
    tick(2);
    chk_evt("rst", 1'b0, 2'd0, 8'h00);
    chk("rst.held", 32'(held), 32'd0);
    chk("rst.err", 32'(err_cnt), 32'd0);
    chk("rst.rej", 32'(rej_cnt), 32'd0);
    chk("rst.drop", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    tick(1);

    // 1: PRESS at N+2, RELEASE after H cycles
    send(32'h00FF_A25D);
    chk_evt("t1.lat", 1'b0, 2'd0, 8'h00);
    tick(1);
    chk_evt("t1.press", 1'b1, 2'd1, 8'hA2);
    chk("t1.held", 32'(held), 32'd1);
    tick(1);
    chk_evt("t1.acc", 1'b0, 2'd0, 8'h00);
    tick(H - 2);
    chk_evt("t1.pre", 1'b0, 2'd0, 8'h00);
    chk("t1.held2", 32'(held), 32'd1);
    tick(1);
    chk_evt("t1.rel", 1'b1, 2'd3, 8'hA2);
    chk("t1.held3", 32'(held), 32'd0);
    tick(1);

    // 2: bad complement, wrong address
    send(32'h00FF_A25C);
    tick(1);
    chk_evt("t2.badcmd", 1'b0, 2'd0, 8'h00);
    chk("t2.rej1", 32'(rej_cnt), 32'd1);
    send(32'h01FE_A25D);
    tick(1);
    chk_evt("t2.badaddr", 1'b0, 2'd0, 8'h00);
    chk("t2.rej2", 32'(rej_cnt), 32'd2);
    chk("t2.held", 32'(held), 32'd0);

    // 3: six re-arrivals -> two REPEATs
    send(32'h00FF_A25D);
    tick(1);
    chk_evt("t3.press", 1'b1, 2'd1, 8'hA2);
    for (int k = 1; k <= 6; k++) begin
      send(32'h00FF_A25D);
      tick(1);
      if (k == 3 || k == 6) chk_evt($sformatf("t3.rep%0d", k), 1'b1, 2'd2, 8'hA2);
      else chk_evt($sformatf("t3.none%0d", k), 1'b0, 2'd0, 8'h00);
    end
    chk("t3.held", 32'(held), 32'd1);
    n = 0;
    for (int k = 0; k < int'(H) - 1; k++) begin
      tick(1);
      if (evt_valid) n++;
    end
    chk("t3.quiet", 32'(n), 32'd0);
    tick(1);
    chk_evt("t3.rel", 1'b1, 2'd3, 8'hA2);
    tick(1);

    // 4: key change -> RELEASE A2, PRESS 62 back to back
    send(32'h00FF_A25D);
    tick(1);
    chk_evt("t4.press", 1'b1, 2'd1, 8'hA2);
    send(32'h00FF_629D);
    tick(1);
    chk_evt("t4.rel", 1'b1, 2'd3, 8'hA2);
    tick(1);
    chk_evt("t4.press2", 1'b1, 2'd1, 8'h62);
    chk("t4.held", 32'(held), 32'd1);
    tick(H - 1);
    chk_evt("t4.rel2", 1'b1, 2'd3, 8'h62);
    tick(1);

    // Frame during CHECK is ignored and counted as rejected
    code = 32'h00FF_A25D;
    new_code = 1'b1;
    tick(1);
    code = 32'h00FF_629D;
    tick(1);
    new_code = 1'b0;
    chk_evt("bb.press", 1'b1, 2'd1, 8'hA2);
    chk("bb.rej", 32'(rej_cnt), 32'd3);
    tick(H);
    chk_evt("bb.rel", 1'b1, 2'd3, 8'hA2);
    tick(1);

    // 5: stalled consumer -> PRESS held, RELEASE dropped
    ready = 1'b0;
    send(32'h00FF_A25D);
    tick(1);
    chk_evt("t5.press", 1'b1, 2'd1, 8'hA2);
    tick(H - 1);
    chk_evt("t5.stable", 1'b1, 2'd1, 8'hA2);
    chk("t5.held", 32'(held), 32'd1);
    tick(1);
    chk_evt("t5.kept", 1'b1, 2'd1, 8'hA2);
    chk("t5.drop", 32'(drop_cnt), 32'd1);
    chk("t5.held2", 32'(held), 32'd0);
    ready = 1'b1;
    tick(1);
    chk_evt("t5.acc", 1'b0, 2'd0, 8'h00);

    // 6: error counter saturation, then reset while HELD
    err = 3'b010;
    tick(10);
    chk("t6.err10", 32'(err_cnt), 32'd10);
    tick(290);
    chk("t6.errsat", 32'(err_cnt), 32'hFF);
    err = 3'b000;
    ready = 1'b0;
    send(32'h00FF_A25D);
    tick(1);
    chk_evt("t6.press", 1'b1, 2'd1, 8'hA2);
    tick(3);
    chk("t6.held", 32'(held), 32'd1);
    rst = 1'b1;
    tick(1);
    chk("t6.rvld", 32'(evt_valid), 32'd0);
    chk("t6.rtype", 32'(evt_type), 32'd0);
    chk("t6.rcmd", 32'(evt_cmd), 32'd0);
    chk("t6.rheld", 32'(held), 32'd0);
    chk("t6.rerr", 32'(err_cnt), 32'd0);
    chk("t6.rrej", 32'(rej_cnt), 32'd0);
    chk("t6.rdrop", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    ready = 1'b1;
    tick(H + 2);
    chk_evt("t6.norel", 1'b0, 2'd0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
